// File: rtl/ulpi_reg_arbiter.sv
// Shares the ULPI register read/write engines between NUM_REQ requesters, one command at a time.
// Optional: define ULPI_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins) instead of round-robin.
module ulpi_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [6*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [7:0]             resp_rdata,
  output logic                   resp_err,
  output logic [5:0]             rd_addr,
  output logic                   rd_en,
  input  logic [7:0]             rd_data,
  input  logic                   rd_data_ready,
  output logic [5:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   wr_en,
  input  logic                   wr_done,
  output logic                   busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e             state_q;
  logic [IDXW-1:0]    owner_q;
  logic [CW-1:0]      tmo_cnt_q;
  logic               rd_en_q;
  logic               wr_en_q;
  logic               busy_q;
  logic               resp_err_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [7:0]         resp_rdata_q;
  logic [5:0]         rd_addr_q;
  logic [5:0]         wr_addr_q;
  logic [7:0]         wr_data_q;
  logic               grant_found_d;
  logic [IDXW-1:0]    grant_idx_d;
  logic [5:0]         addr_a  [NUM_REQ];
  logic [7:0]         wdata_a [NUM_REQ];

`ifndef ULPI_ARB_FIXED_PRIORITY_EN
  logic [IDXW-1:0]    last_grant_q;
`endif

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
    return NUM_REQ'(1'b1) << idx;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g]  = req_addr[6*g +: 6];
    assign wdata_a[g] = req_wdata[8*g +: 8];
  end

  // Winner scan: starts after the last grant (round-robin) or at index 0 (fixed priority).
  always_comb begin
    logic [IDXW:0]   scan;
    logic [IDXW-1:0] sel;
    logic            take;
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    scan          = '0;
    sel           = '0;
    take          = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ULPI_ARB_FIXED_PRIORITY_EN
      scan = (IDXW+1)'(k);
`else
      scan = {1'b0, last_grant_q} + (IDXW+1)'(k + 1);
      scan = (scan >= (IDXW+1)'(NUM_REQ)) ? scan - (IDXW+1)'(NUM_REQ) : scan;
`endif
      sel           = scan[IDXW-1:0];
      take          = !grant_found_d && req_valid[sel];
      grant_idx_d   = take ? sel : grant_idx_d;
      grant_found_d = grant_found_d | take;
    end
  end

  assign req_ready  = (!reset && state_q == IDLE && grant_found_d) ? idx_onehot(grant_idx_d)
                                                                  : {NUM_REQ{1'b0}};
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign busy       = busy_q;

  // Command FSM; enables and responses are registered so they change only on clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      tmo_cnt_q    <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= 8'h00;
      rd_addr_q    <= 6'h00;
      wr_addr_q    <= 6'h00;
      wr_data_q    <= 8'h00;
`ifndef ULPI_ARB_FIXED_PRIORITY_EN
      last_grant_q <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      resp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_found_d) begin
            owner_q   <= grant_idx_d;
            tmo_cnt_q <= '0;
            busy_q    <= 1'b1;
`ifndef ULPI_ARB_FIXED_PRIORITY_EN
            last_grant_q <= grant_idx_d;
`endif
            if (req_write[grant_idx_d]) begin
              state_q   <= WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_a[grant_idx_d];
              wr_data_q <= wdata_a[grant_idx_d];
            end else begin
              state_q   <= READ;
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_a[grant_idx_d];
            end
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (rd_data_ready) begin
            rd_en_q      <= 1'b0;
            resp_rdata_q <= rd_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= idx_onehot(owner_q);
            state_q      <= RESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            rd_en_q      <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_err_q   <= 1'b1;
            resp_valid_q <= idx_onehot(owner_q);
            state_q      <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        WRITE: begin
          if (wr_done || tmo_cnt_q == TMO_LAST) begin
            wr_en_q      <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_err_q   <= !wr_done;
            resp_valid_q <= idx_onehot(owner_q);
            state_q      <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        RESP: begin
          state_q <= GAP;
        end
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: directed cases then randomized commands checked
// against a transaction-level model (winner rotation, latency vs. timeout).
module tb_ulpi_reg_arbiter;

  localparam int N   = 3;
  localparam int TMO = 8;
  localparam int AW  = 6 * N;
  localparam int DW  = 8 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  resp_valid;
  logic [7:0]    resp_rdata;
  logic          resp_err;
  logic [5:0]    rd_addr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_data_ready;
  logic [5:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          wr_done;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int last_grant = N - 1;

  ulpi_reg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_data_ready(rd_data_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'd1 << i;
  endfunction

  // Reference arbitration: rotate priority starting just after the previous winner.
  function automatic int model_winner(input logic [N-1:0] mask);
    int m;
    m = int'(mask);
`ifdef ULPI_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (((m >> i) & 1) != 0) return i;
`else
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (last_grant + off) % N;
      if (((m >> i) & 1) != 0) return i;
    end
`endif
    return -1;
  endfunction

  // One full command: IDLE grant, engine phase of lat cycles (or timeout), RESP, GAP.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] wr_bits,
                         input logic [AW-1:0] addrs, input logic [DW-1:0] wdatas,
                         input int lat, input logic [7:0] cdata, input bit strays);
    int         w;
    int         n_eng;
    bit         is_wr;
    bit         exp_err;
    logic [5:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_rdata;
    @(negedge clk);
    req_valid     = mask;
    req_write     = wr_bits;
    req_addr      = addrs;
    req_wdata     = wdatas;
    rd_data       = 8'($urandom);
    rd_data_ready = strays ? 1'($urandom_range(0, 1)) : 1'b0;
    wr_done       = strays ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_en", 32'({rd_en, wr_en}), 32'd0);
    w = model_winner(mask);
    if (w < 0) begin
      check_val("idle_no_grant", 32'(req_ready), 32'd0);
      return;
    end
    check_val("grant", 32'(req_ready), oh(w));
    last_grant = w;
    is_wr     = ((int'(wr_bits) >> w) & 1) != 0;
    exp_addr  = 6'(addrs >> (6 * w));
    exp_wdata = 8'(wdatas >> (8 * w));
    exp_err   = lat > TMO;
    exp_rdata = (is_wr || exp_err) ? 8'h00 : cdata;
    n_eng     = exp_err ? TMO : lat;
    for (int k = 1; k <= n_eng; k++) begin
      @(negedge clk);
      rd_data       = (k == lat) ? cdata : 8'($urandom);
      rd_data_ready = (!is_wr && k == lat) || (strays && is_wr && $urandom_range(0, 2) == 0);
      wr_done       = (is_wr && k == lat) || (strays && !is_wr && $urandom_range(0, 2) == 0);
      #1;
      check_val("eng_en", 32'({rd_en, wr_en}), is_wr ? 32'd1 : 32'd2);
      check_val("eng_ready", 32'(req_ready), 32'd0);
      check_val("eng_resp", 32'(resp_valid), 32'd0);
      check_val("eng_busy", 32'(busy), 32'd1);
      if (is_wr) begin
        check_val("wr_addr", 32'(wr_addr), 32'(exp_addr));
        check_val("wr_data", 32'(wr_data), 32'(exp_wdata));
      end else begin
        check_val("rd_addr", 32'(rd_addr), 32'(exp_addr));
      end
    end
    @(negedge clk);
    rd_data_ready = 1'b0;
    wr_done       = 1'b0;
    rd_data       = 8'($urandom);
    #1;
    check_val("resp_valid", 32'(resp_valid), oh(w));
    check_val("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    check_val("resp_err", 32'(resp_err), 32'(exp_err));
    check_val("resp_en", 32'({rd_en, wr_en}), 32'd0);
    check_val("resp_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    check_val("gap_resp", 32'(resp_valid), 32'd0);
    check_val("gap_en", 32'({rd_en, wr_en}), 32'd0);
    check_val("gap_ready", 32'(req_ready), 32'd0);
    check_val("gap_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
    rd_data = 8'h00; rd_data_ready = 1'b0; wr_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_en", 32'({rd_en, wr_en}), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp", 32'({resp_valid, resp_err, resp_rdata}), 32'd0);
    check_val("rst_addr", 32'({rd_addr, wr_addr, wr_data}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;

    // Contention: requesters 0 and 1 both valid.
    for (int i = 0; i < 4; i++) run_txn(3'b011, 3'b000, AW'($urandom), DW'($urandom),
                                        int'($urandom_range(1, 4)), 8'($urandom), 1'b0);
    run_txn(3'b001, 3'b000, {N{6'h16}}, {N{8'h00}}, 5, 8'hA5, 1'b0);
    run_txn(3'b010, 3'b010, {N{6'h04}}, {N{8'h48}}, 3, 8'h00, 1'b0);
    run_txn(3'b100, 3'b000, {N{6'h3F}}, {N{8'h00}}, TMO + 2, 8'h77, 1'b0);
    run_txn(3'b001, 3'b000, {N{6'h21}}, {N{8'h00}}, TMO, 8'h5C, 1'b0);
    run_txn(3'b010, 3'b010, {N{6'h11}}, {N{8'hC3}}, TMO + 1, 8'h00, 1'b0);
    run_txn(3'b100, 3'b100, {N{6'h0A}}, {N{8'h9E}}, TMO, 8'h00, 1'b0);
    run_txn(3'b001, 3'b000, {N{6'h07}}, {N{8'h00}}, 4, 8'h3D, 1'b1);
    run_txn(3'b000, 3'b000, '0, '0, 1, 8'h00, 1'b1);

    // Reset in the middle of a read.
    @(negedge clk);
    req_valid = 3'b100; req_write = '0; req_addr = {N{6'h2A}};
    rd_data_ready = 1'b0; wr_done = 1'b0;
    #1;
    check_val("mid_grant", 32'(req_ready), oh(model_winner(3'b100)));
    @(negedge clk);
    req_valid = '0;
    #1;
    check_val("mid_rd_en", 32'(rd_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_en", 32'(rd_en), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    last_grant = N - 1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    run_txn(3'b011, 3'b000, AW'($urandom), DW'($urandom), 2, 8'hE1, 1'b0);

    for (int t = 0; t < 200; t++) begin
      logic [N-1:0] m;
      m = N'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      run_txn(m, N'($urandom), AW'($urandom), DW'($urandom),
              int'($urandom_range(1, TMO + 3)), 8'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
